drive_burst_sequencer: RTL

Programmable burst generator for the piezo drive clock path. Each run produces a counted train of square pulses at a runtime-selected half-period, derived from the board input clock. Start/abort handshake and clean burst boundaries let the motor command layer sequence moves without truncated drive pulses. It sits between the command decoder and the driver output stage and replaces fixed-ratio division where step count and frequency vary per move.

---
 rtl/drive_burst_sequencer_if.sv | 28 ++
 rtl/drive_burst_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/drive_burst_sequencer_if.sv
// Command/status bundle between the motor command decoder (master) and the
// burst sequencer (slave). The debug state mirror lets checkers follow the FSM.
interface drive_burst_sequencer_if #(
    parameter int HALF_W  = 16,
    parameter int COUNT_W = 16
);
    logic               start;
    logic [HALF_W-1:0]  half_period;
    logic [COUNT_W-1:0] n_pulses;
    logic               abort;
    logic               out_clk;
    logic               busy;
    logic               done;
    logic               aborted;
    logic               cfg_err;
    logic [COUNT_W-1:0] pulses_done;
    logic [1:0]         dbg_state;

    modport master (
        output start, half_period, n_pulses, abort,
        input  out_clk, busy, done, aborted, cfg_err, pulses_done, dbg_state
    );

    modport slave (
        input  start, half_period, n_pulses, abort,
        output out_clk, busy, done, aborted, cfg_err, pulses_done, dbg_state
    );
endinterface

// File: rtl/drive_burst_sequencer.sv
// Counted square-wave burst generator: N pulses of H high + H low in_clk cycles,
// with start/abort handshake and abort taking effect only at a pulse boundary.
module drive_burst_sequencer #(
    parameter int IN_FREQ_KHZ = 16000,
    parameter int HALF_W      = 16,
    parameter int COUNT_W     = 16
) (
    input  logic                     in_clk,
    input  logic                     reset_n,
    drive_burst_sequencer_if.slave   bus
);
    // Handshake: start is a one-cycle request honoured only when idle (not busy and
    // not already armed); the burst owns the config until done, which is a one-cycle
    // completion strobe; abort is a level/pulse request sampled only while busy.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // The input clock rate only documents the timing of half_period.
    if (IN_FREQ_KHZ > 0) begin : g_in_freq_doc
    end

    state_t             state_q, state_d;
    logic               arm_q, arm_d;
    logic [HALF_W-1:0]  phase_q, phase_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic [COUNT_W-1:0] n_q, n_d;
    logic [COUNT_W-1:0] pulses_q, pulses_d;
    logic               abort_q, abort_d;
    logic               out_clk_q, out_clk_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               cfg_err_q, cfg_err_d;

    logic idle_free;
    logic cfg_bad;
    logic start_ok;
    logic start_bad;
    logic running;
    logic phase_end;
    logic low_end;
    logic last_pulse;
    logic abort_now;
    logic burst_end;

    always_comb begin
        idle_free  = (state_q == IDLE) && !arm_q;
        cfg_bad    = (bus.half_period == '0) || (bus.n_pulses == '0);
        start_ok   = bus.start && idle_free && !cfg_bad;
        start_bad  = bus.start && idle_free && cfg_bad;
        running    = (state_q != IDLE);
        phase_end  = (phase_q == half_q - HALF_W'(1));
        low_end    = (state_q == LOW) && phase_end;
        last_pulse = (pulses_q == n_q - COUNT_W'(1));
        abort_now  = abort_q || (bus.abort && running);
        burst_end  = low_end && (last_pulse || abort_now);
    end

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            arm_q     <= 1'b0;
            phase_q   <= '0;
            half_q    <= '0;
            n_q       <= '0;
            pulses_q  <= '0;
            abort_q   <= 1'b0;
            out_clk_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_q     <= arm_d;
            phase_q   <= phase_d;
            half_q    <= half_d;
            n_q       <= n_d;
            pulses_q  <= pulses_d;
            abort_q   <= abort_d;
            out_clk_q <= out_clk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // The armed cycle delays entry to HIGH so the first rise lands one cycle after the start edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm_q) state_d = HIGH;
            HIGH:    if (phase_end) state_d = LOW;
            LOW:     if (phase_end) state_d = burst_end ? IDLE : HIGH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arm_d     = start_ok;
        half_d    = half_q;
        n_d       = n_q;
        pulses_d  = pulses_q;
        abort_d   = abort_q;
        aborted_d = aborted_q;
        phase_d   = '0;

        if (running && !phase_end) phase_d = phase_q + HALF_W'(1);

        if (start_ok) begin
            half_d    = bus.half_period;
            n_d       = bus.n_pulses;
            pulses_d  = '0;
            abort_d   = 1'b0;
            aborted_d = 1'b0;
        end

        if (running && bus.abort) abort_d = 1'b1;
        if (low_end) pulses_d = pulses_q + COUNT_W'(1);
        if (burst_end) begin
            abort_d   = 1'b0;
            aborted_d = abort_now;
        end

        done_d    = burst_end;
        cfg_err_d = start_bad;
        out_clk_d = (state_d == HIGH);
        busy_d    = (state_d != IDLE);
    end

    assign bus.out_clk     = out_clk_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.pulses_done = pulses_q;
    assign bus.dbg_state   = state_q;
endmodule
